// File: rtl/toggle_bank.sv
// Multi-channel debounced toggle stage: sync chain, stability filter,
// selectable edge trigger and one-cycle change strobes per channel.
module toggle_bank #(
  parameter int                  CHANNELS    = 4,
  parameter int                  SYNC_STAGES = 2,
  parameter int                  DEBOUNCE    = 16,
  parameter logic [CHANNELS-1:0] INIT        = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CHANNELS-1:0]   din,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic                  clr,
  output logic [CHANNELS-1:0]   dout,
  output logic [CHANNELS-1:0]   changed
);

  typedef enum logic [1:0] {
    M_RISE  = 2'd0,
    M_FALL  = 2'd1,
    M_BOTH  = 2'd2,
    M_LEVEL = 2'd3
  } mode_e;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   db_q;
    logic                   db_d;
    logic                   rise;
    logic                   fall;
    logic                   dout_q;
    logic                   dout_d;
    logic                   chg_q;
    logic                   chg_d;
    mode_e                  md;

    assign md = mode_e'(mode[2*i +: 2]);
    assign s  = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], din[i]};
      end
    end

    if (DEBOUNCE >= 2) begin : g_db
      localparam int CW = $clog2(DEBOUNCE + 1);

      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;

      // Any cycle agreeing with the accepted level restarts the count.
      always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        if (s == db_q) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE - 1)) begin
          db_d  = s;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end else begin : g_nodb
      assign db_d = s;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        db_q <= 1'b0;
      end else begin
        db_q <= db_d;
      end
    end

    assign rise = ~db_q &  db_d;
    assign fall =  db_q & ~db_d;

    always_comb begin
      dout_d = dout_q;
      unique case (md)
        M_RISE:  if (rise)        dout_d = ~dout_q;
        M_FALL:  if (fall)        dout_d = ~dout_q;
        M_BOTH:  if (rise | fall) dout_d = ~dout_q;
        M_LEVEL: dout_d = db_d;
      endcase
      if (clr) begin
        dout_d = INIT[i];
      end
      chg_d = ~clr & (dout_d != dout_q);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_q <= INIT[i];
        chg_q  <= 1'b0;
      end else begin
        dout_q <= dout_d;
        chg_q  <= chg_d;
      end
    end

    assign dout[i]    = dout_q;
    assign changed[i] = chg_q;

  end

endmodule

// File: tb/tb_toggle_bank.sv
// Bench for toggle_bank: per-cycle vector table with an expectation
// queue, plus hand sequences for reset behaviour.
module tb_toggle_bank;

  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [CH-1:0] din = '0;
  logic [2*CH-1:0] mode = '0;
  logic          clr = 1'b0;
  logic [CH-1:0] dout;
  logic [CH-1:0] changed;

  toggle_bank #(
    .CHANNELS(CH),
    .SYNC_STAGES(2),
    .DEBOUNCE(4),
    .INIT(4'b0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .mode(mode),
    .clr(clr),
    .dout(dout),
    .changed(changed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CH-1:0]   din;
    logic [2*CH-1:0] mode;
    logic            clr;
    int              n;
    logic [CH-1:0]   dout;
    logic [CH-1:0]   chg;
  } vec_t;

  typedef struct {
    logic [CH-1:0] dout;
    logic [CH-1:0] chg;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   stepno = 0;

  function automatic vec_t mk(logic [CH-1:0] d, logic [2*CH-1:0] m,
                              logic c, int n, logic [CH-1:0] o,
                              logic [CH-1:0] g);
    vec_t v;
    v.din = d; v.mode = m; v.clr = c; v.n = n; v.dout = o; v.chg = g;
    return v;
  endfunction

  task automatic chk(string name, logic [CH-1:0] act, logic [CH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%b exp=%b", name, stepno, act, exp);
    end
  endtask

  task automatic step(vec_t v);
    exp_t e;
    din  = v.din;
    mode = v.mode;
    clr  = v.clr;
    e.dout = v.dout;
    e.chg  = v.chg;
    sb.push_back(e);
    @(posedge clk);
    #1;
    stepno++;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty step=%0d got=0 exp=1", stepno);
    end else begin
      e = sb.pop_front();
      chk("dout", dout, e.dout);
      chk("changed", changed, e.chg);
    end
  endtask

  task automatic run(vec_t v);
    for (int k = 0; k < v.n; k++) step(v);
  endtask

  initial begin
    // mode 0, ch0: rise toggles, fall ignored
    tbl.push_back(mk(4'b0001, 8'h00, 0, 5,  4'b0000, 4'b0000));
    tbl.push_back(mk(4'b0001, 8'h00, 0, 1,  4'b0001, 4'b0001));
    tbl.push_back(mk(4'b0001, 8'h00, 0, 4,  4'b0001, 4'b0000));
    tbl.push_back(mk(4'b0000, 8'h00, 0, 10, 4'b0001, 4'b0000));
    // repeat pulse toggles back
    tbl.push_back(mk(4'b0001, 8'h00, 0, 5,  4'b0001, 4'b0000));
    tbl.push_back(mk(4'b0001, 8'h00, 0, 1,  4'b0000, 4'b0001));
    tbl.push_back(mk(4'b0001, 8'h00, 0, 4,  4'b0000, 4'b0000));
    tbl.push_back(mk(4'b0000, 8'h00, 0, 10, 4'b0000, 4'b0000));
    // glitch on ch1 rejected, 4-cycle pulse accepted
    tbl.push_back(mk(4'b0010, 8'h00, 0, 3,  4'b0000, 4'b0000));
    tbl.push_back(mk(4'b0000, 8'h00, 0, 10, 4'b0000, 4'b0000));
    tbl.push_back(mk(4'b0010, 8'h00, 0, 4,  4'b0000, 4'b0000));
    tbl.push_back(mk(4'b0000, 8'h00, 0, 1,  4'b0000, 4'b0000));
    tbl.push_back(mk(4'b0000, 8'h00, 0, 1,  4'b0010, 4'b0010));
    tbl.push_back(mk(4'b0000, 8'h00, 0, 10, 4'b0010, 4'b0000));
    // mode 2 on ch2: both edges
    tbl.push_back(mk(4'b0100, 8'h20, 0, 5,  4'b0010, 4'b0000));
    tbl.push_back(mk(4'b0100, 8'h20, 0, 1,  4'b0110, 4'b0100));
    tbl.push_back(mk(4'b0100, 8'h20, 0, 4,  4'b0110, 4'b0000));
    tbl.push_back(mk(4'b0000, 8'h20, 0, 5,  4'b0110, 4'b0000));
    tbl.push_back(mk(4'b0000, 8'h20, 0, 1,  4'b0010, 4'b0100));
    tbl.push_back(mk(4'b0000, 8'h20, 0, 5,  4'b0010, 4'b0000));
    // mode 1 on ch3: falling edge only
    tbl.push_back(mk(4'b1000, 8'h40, 0, 10, 4'b0010, 4'b0000));
    tbl.push_back(mk(4'b0000, 8'h40, 0, 5,  4'b0010, 4'b0000));
    tbl.push_back(mk(4'b0000, 8'h40, 0, 1,  4'b1010, 4'b1000));
    tbl.push_back(mk(4'b0000, 8'h40, 0, 5,  4'b1010, 4'b0000));
    // mode 3 on ch0, then clr
    tbl.push_back(mk(4'b0001, 8'h03, 0, 5,  4'b1010, 4'b0000));
    tbl.push_back(mk(4'b0001, 8'h03, 0, 1,  4'b1011, 4'b0001));
    tbl.push_back(mk(4'b0001, 8'h03, 0, 2,  4'b1011, 4'b0000));
    tbl.push_back(mk(4'b0001, 8'h03, 1, 1,  4'b0000, 4'b0000));
    tbl.push_back(mk(4'b0001, 8'h03, 0, 1,  4'b0001, 4'b0001));
    tbl.push_back(mk(4'b0001, 8'h03, 0, 3,  4'b0001, 4'b0000));
    // back to mode 0: dout holds, debounced fall ignored
    tbl.push_back(mk(4'b0000, 8'h00, 0, 10, 4'b0001, 4'b0000));

    #1 rst = 1'b1;
    #1;
    chk("reset_dout", dout, 4'b0000);
    chk("reset_changed", changed, 4'b0000);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    foreach (tbl[k]) run(tbl[k]);

    // async reset in the middle of a debounce count
    run(mk(4'b0001, 8'h00, 0, 3, 4'b0001, 4'b0000));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_dout", dout, 4'b0000);
    chk("async_rst_changed", changed, 4'b0000);
    din = 4'b0000;
    @(posedge clk);
    #1;
    chk("rst_held_dout", dout, 4'b0000);
    rst = 1'b0;
    run(mk(4'b0000, 8'h00, 0, 10, 4'b0000, 4'b0000));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
